trace_buffer: RTL and testbench

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_buffer_if.sv | 47 ++++
 rtl/trace_buffer.sv | 172 +++++++++++++++++
 tb/tb_trace_buffer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_buffer_if.sv
// ---------------------------------------------------------------------------
// trace_buffer_if
//   Bundles the capture, configuration and drain signals of trace_buffer.
//   master : upstream packer / host side (drives capture, config, ready_in)
//   slave  : trace_buffer side (drives drained vector, status flags)
//   Signals:
//     tracing      1 = capture mode, 0 = configuration/readout mode
//     valid_in     vector_in holds a packed vector this cycle
//     vector_in    N lanes x DATA_WIDTH packed vector
//     configId     configuration target ID
//     configData   command byte (8'h01 DRAIN, 8'h02 CLEAR)
//     ready_in     host accepts vector_out this cycle
//     vector_out   drained vector (registered)
//     valid_out    vector_out is valid
//     count_out    number of stored vectors, 0..TB_SIZE
//     overflow     sticky drop/overwrite flag
//     drain_done   one-cycle pulse after the last drained vector is accepted
// ---------------------------------------------------------------------------
interface trace_buffer_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TB_SIZE    = 8
);
    localparam int CW = $clog2(TB_SIZE) + 1;

    logic                             tracing;
    logic                             valid_in;
    logic [N-1:0][DATA_WIDTH-1:0]     vector_in;
    logic [7:0]                       configId;
    logic [7:0]                       configData;
    logic                             ready_in;
    logic [N-1:0][DATA_WIDTH-1:0]     vector_out;
    logic                             valid_out;
    logic [CW-1:0]                    count_out;
    logic                             overflow;
    logic                             drain_done;

    modport master (
        output tracing, valid_in, vector_in, configId, configData, ready_in,
        input  vector_out, valid_out, count_out, overflow, drain_done
    );

    modport slave (
        input  tracing, valid_in, vector_in, configId, configData, ready_in,
        output vector_out, valid_out, count_out, overflow, drain_done
    );
endinterface

// File: rtl/trace_buffer.sv
// ---------------------------------------------------------------------------
// trace_buffer
//   Circular capture buffer of TB_SIZE packed vectors. In TRACE it records
//   every valid input vector; in IDLE a DRAIN command streams the stored
//   vectors out oldest-first over a valid/ready handshake, a CLEAR command
//   empties the buffer.
//
//   Ports:
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    trace_buffer_if.slave (capture, config, drain and status)
//
//   Build option:
//     TRACE_BUFFER_OVERWRITE_EN  defined   : a write into a full buffer
//                                            replaces the oldest entry
//                                undefined : a write into a full buffer is
//                                            dropped
//     Either way the sticky overflow flag is set.
// ---------------------------------------------------------------------------
module trace_buffer #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int TB_SIZE            = 8,
    parameter int PERSONAL_CONFIG_ID = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    trace_buffer_if.slave bus
);
    localparam int PW = $clog2(TB_SIZE);
    localparam int CW = PW + 1;

    localparam logic [7:0] CMD_DRAIN = 8'h01;
    localparam logic [7:0] CMD_CLEAR = 8'h02;

    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
    typedef enum logic [1:0] {S_IDLE, S_TRACE, S_DRAIN} state_t;

    state_t        r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    vec_t          r_vec_out;
    logic          r_valid_out;
    logic          r_overflow;
    logic          r_drain_done;

    // Storage is deliberately not reset.
    vec_t          r_mem [TB_SIZE];

    logic          w_cmd_hit;
    logic          w_drain_cmd;
    logic          w_clear_cmd;
    logic          w_full;
    logic          w_wr_req;
    logic          w_mem_we;
    logic          w_accept;
    logic          w_last;
    logic          w_load;
    logic [PW-1:0] w_ld_addr;

    // Commands are only honoured while idle and not tracing.
    assign w_cmd_hit   = (r_state == S_IDLE) && !bus.tracing &&
                         (bus.configId == 8'(PERSONAL_CONFIG_ID));
    assign w_drain_cmd = w_cmd_hit && (bus.configData == CMD_DRAIN) &&
                         (r_count != '0);
    assign w_clear_cmd = w_cmd_hit && (bus.configData == CMD_CLEAR);

    assign w_full      = (r_count == CW'(TB_SIZE));
    assign w_wr_req    = (r_state == S_TRACE) && bus.valid_in;

`ifdef TRACE_BUFFER_OVERWRITE_EN
    // When full, wr_ptr points at the oldest entry, so writing there and
    // advancing both overwrites it and keeps the window contiguous.
    assign w_mem_we    = w_wr_req;
`else
    assign w_mem_we    = w_wr_req && !w_full;
`endif

    assign w_accept    = r_valid_out && bus.ready_in;
    assign w_last      = w_accept && (r_count == CW'(1));

    // The output register holds the entry at rd_ptr. A fresh entry is
    // fetched when the register is empty, or when the current one is being
    // accepted and more entries remain -- this sustains one vector per
    // cycle. The fetch address skips the entry currently being handed off.
    assign w_load      = (r_state == S_DRAIN) && !bus.tracing &&
                         ((!r_valid_out && (r_count != '0)) ||
                          (w_accept && (r_count > CW'(1))));
    assign w_ld_addr   = r_valid_out ? (r_rd_ptr + 1'b1) : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[r_wr_ptr] <= bus.vector_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_vec_out    <= '0;
            r_valid_out  <= 1'b0;
            r_overflow   <= 1'b0;
            r_drain_done <= 1'b0;
        end else begin
            r_drain_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.tracing) begin
                        r_state <= S_TRACE;
                    end else if (w_clear_cmd) begin
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end else if (w_drain_cmd) begin
                        // Oldest entry sits count slots behind wr_ptr; with a
                        // full buffer this wraps to wr_ptr itself.
                        r_rd_ptr <= r_wr_ptr - r_count[PW-1:0];
                        r_state  <= S_DRAIN;
                    end
                end

                S_TRACE: begin
                    if (w_mem_we)
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_wr_req && !w_full)
                        r_count <= r_count + 1'b1;
                    if (w_wr_req && w_full)
                        r_overflow <= 1'b1;
                    if (!bus.tracing)
                        r_state <= S_IDLE;
                end

                S_DRAIN: begin
                    if (bus.tracing) begin
                        // Abort: discard what is left and resume capture.
                        r_valid_out <= 1'b0;
                        r_count     <= '0;
                        r_state     <= S_TRACE;
                    end else begin
                        if (w_load) begin
                            r_vec_out   <= r_mem[w_ld_addr];
                            r_valid_out <= 1'b1;
                        end else if (w_accept) begin
                            r_valid_out <= 1'b0;
                        end
                        if (w_accept) begin
                            r_count  <= r_count - 1'b1;
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                        if (w_last) begin
                            r_drain_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.vector_out = r_vec_out;
    assign bus.valid_out  = r_valid_out;
    assign bus.count_out  = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.drain_done = r_drain_done;

endmodule

// File: tb/tb_trace_buffer.sv
module tb_trace_buffer;
    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int TBS = 8;
    localparam int ID  = 1;

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trace_buffer_if #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(TBS)) bus ();

    trace_buffer #(
        .N(N), .DATA_WIDTH(DW), .TB_SIZE(TBS), .PERSONAL_CONFIG_ID(ID)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_chk    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   acc_cnt  = 0;

    // Reference model: the stored window as a plain FIFO of vectors.
    vec_t mdl[$];
    logic mdl_ovf = 1'b0;
    // Scoreboard: vectors the host is expected to receive, in order.
    vec_t sb[$];

    bit   prev_stall = 1'b0;
    vec_t prev_vec;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: consumes every handshake independently of the stimulus.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                n_chk++;
                if (bus.valid_out !== 1'b1 || bus.vector_out !== prev_vec) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%0b vec=%h required valid=1 vec=%h",
                             bus.valid_out, bus.vector_out, prev_vec);
                end
            end
            if (bus.valid_out && bus.ready_in) begin
                n_chk++;
                acc_cnt++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got vec=%h with no vector expected", bus.vector_out);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    if (bus.vector_out !== e) begin
                        n_fail++;
                        $display("FAIL drain_data: got %h expected %h", bus.vector_out, e);
                    end
                end
            end
            if (bus.drain_done) begin
                done_cnt++;
                n_chk++;
                if (sb.size() != 0) begin
                    n_fail++;
                    $display("FAIL early_done: got drain_done with %0d vectors outstanding, required 0",
                             sb.size());
                end
            end
            prev_stall = bus.valid_out && !bus.ready_in && !bus.tracing;
            prev_vec   = bus.vector_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t vall(input int v);
        vec_t r;
        for (int i = 0; i < N; i++) r[i] = DW'(v);
        return r;
    endfunction

    function automatic vec_t vrand();
        vec_t r;
        for (int i = 0; i < N; i++) r[i] = $urandom;
        return r;
    endfunction

    task automatic write(input vec_t v);
        bus.valid_in  = 1'b1;
        bus.vector_in = v;
        cyc();
        bus.valid_in  = 1'b0;
        if (mdl.size() < TBS) begin
            mdl.push_back(v);
        end else begin
`ifdef TRACE_BUFFER_OVERWRITE_EN
            void'(mdl.pop_front());
            mdl.push_back(v);
`endif
            mdl_ovf = 1'b1;
        end
    endtask

    task automatic start_trace();
        bus.tracing = 1'b1;
        cyc();
    endtask

    task automatic stop_trace();
        bus.tracing = 1'b0;
        cyc();
    endtask

    task automatic send_cmd(input int id, input int d);
        bus.configId   = 8'(id);
        bus.configData = 8'(d);
        cyc();
        bus.configId   = 8'h00;
        bus.configData = 8'h00;
    endtask

    task automatic set_ready(input int mode, input int t);
        case (mode)
            0:       bus.ready_in = 1'b1;
            1:       bus.ready_in = ((t % 4) == 0) || ((t % 4) == 3);
            default: bus.ready_in = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Issue DRAIN from IDLE and wait for the whole window to come out.
    // exp_t > 0 checks the cycle at which completion is first observed.
    task automatic drain(input int mode, input int exp_t);
        int n;
        int prev;
        int t;
        n    = mdl.size();
        prev = done_cnt;
        set_ready(mode, 0);
        foreach (mdl[i]) sb.push_back(mdl[i]);
        mdl.delete();
        send_cmd(ID, 1);
        t = 1;
        if (n > 0) begin
            chk("lat_cycle1_valid", bus.valid_out, 0);
            set_ready(mode, 1);
            cyc();
            t = 2;
            chk("lat_cycle2_valid", bus.valid_out, 1);
            while (done_cnt == prev && t < 300) begin
                set_ready(mode, t);
                cyc();
                t++;
            end
            chk("drain_done_pulses", done_cnt - prev, 1);
            chk("sb_empty", sb.size(), 0);
            chk("count_after_drain", bus.count_out, 0);
            chk("valid_after_drain", bus.valid_out, 0);
            if (exp_t > 0) chk("drain_cycles", t, exp_t);
        end else begin
            repeat (4) cyc();
            chk("empty_drain_done", done_cnt - prev, 0);
            chk("empty_drain_valid", bus.valid_out, 0);
        end
        bus.ready_in = 1'b1;
    endtask

    task automatic clear_all();
        send_cmd(ID, 2);
        mdl.delete();
        mdl_ovf = 1'b0;
        chk("clear_count", bus.count_out, 0);
        chk("clear_overflow", bus.overflow, 0);
    endtask

    initial begin
        int   acc0;
        int   done0;
        int   k;
        bus.tracing    = 1'b0;
        bus.valid_in   = 1'b0;
        bus.vector_in  = '0;
        bus.configId   = 8'h00;
        bus.configData = 8'h00;
        bus.ready_in   = 1'b1;

        #3;
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_count", bus.count_out, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_done", bus.drain_done, 0);
        chk("rst_vec", bus.vector_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Basic 3-vector capture and drain at full rate.
        start_trace();
        for (int v = 1; v <= 3; v++) write(vall(v));
        stop_trace();
        chk("basic_count", bus.count_out, 3);
        drain(0, 6);

        // Write 10 into an 8-deep buffer.
        start_trace();
        for (int v = 1; v <= 10; v++) write(vall(v));
        stop_trace();
        chk("ovf_count", bus.count_out, TBS);
        chk("ovf_flag", bus.overflow, 1);
        drain(0, TBS + 3);
        chk("ovf_sticky", bus.overflow, mdl_ovf);
        clear_all();

        // Backpressure: ready toggling 1,0,0,1.
        start_trace();
        for (int i = 0; i < 4; i++) write(vrand());
        stop_trace();
        drain(1, 0);

        // Abort after two of five vectors are accepted.
        start_trace();
        for (int i = 0; i < 5; i++) write(vrand());
        stop_trace();
        foreach (mdl[i]) sb.push_back(mdl[i]);
        mdl.delete();
        acc0  = acc_cnt;
        done0 = done_cnt;
        bus.ready_in = 1'b1;
        send_cmd(ID, 1);
        cyc();
        cyc();
        cyc();
        bus.tracing   = 1'b1;
        bus.ready_in  = 1'b0;
        bus.valid_in  = 1'b1;      // must not be captured in the abort cycle
        bus.vector_in = vrand();
        cyc();
        bus.valid_in  = 1'b0;
        bus.ready_in  = 1'b1;
        chk("abort_valid", bus.valid_out, 0);
        chk("abort_count", bus.count_out, 0);
        chk("abort_accepted", acc_cnt - acc0, 2);
        chk("abort_no_done", done_cnt - done0, 0);
        sb.delete();
        for (int i = 0; i < 2; i++) write(vrand());
        stop_trace();
        chk("post_abort_count", bus.count_out, 2);
        drain(2, 0);

        // Reset in the middle of a drain.
        start_trace();
        for (int i = 0; i < 4; i++) write(vrand());
        stop_trace();
        foreach (mdl[i]) sb.push_back(mdl[i]);
        mdl.delete();
        done0 = done_cnt;
        send_cmd(ID, 1);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.valid_out, 0);
        chk("midrst_count", bus.count_out, 0);
        sb.delete();
        mdl_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("midrst_no_done", done_cnt - done0, 0);
        drain(0, 0);

        // Wrong ID drain; CLEAR while tracing.
        start_trace();
        for (int i = 0; i < 2; i++) write(vrand());
        stop_trace();
        send_cmd(ID + 1, 1);
        repeat (3) cyc();
        chk("wrongid_valid", bus.valid_out, 0);
        chk("wrongid_count", bus.count_out, 2);
        start_trace();
        send_cmd(ID, 2);
        stop_trace();
        chk("clr_tracing_count", bus.count_out, 2);
        drain(0, 5);

        // Randomized rounds with random backpressure.
        for (int r = 0; r < 6; r++) begin
            start_trace();
            k = $urandom_range(1, 13);
            for (int i = 0; i < k; i++) write(vrand());
            stop_trace();
            chk("rand_count", bus.count_out, mdl.size());
            chk("rand_overflow", bus.overflow, mdl_ovf);
            drain(2, 0);
            clear_all();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
